memory_request_initiator: RTL and testbench

//   Host-side initiator for the memory manager's CPU port. Accepts pixel read/write commands
//   (x, y, data) over a valid/ready interface and buffers them in a small FIFO.

---
 rtl/g76_mem_pkg.sv | 33 +++
 rtl/command_fifo.sv | 53 +++++
 rtl/memory_request_initiator.sv | 183 ++++++++++++++++++
 tb/tb_memory_request_initiator.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/g76_mem_pkg.sv
// Shared types and constants for the memory request initiator.
//   DefaultScreenWidth/DefaultScreenHeight : default pixel bounds
//   initiator_state_t                      : request FSM states
//   mem_cmd_t                              : one buffered host command
//   pixel_addr()                           : packs a command into the {y, x} RAM address
package g76_mem_pkg;

  localparam int unsigned DefaultScreenWidth  = 320;
  localparam int unsigned DefaultScreenHeight = 240;
  localparam int unsigned CoordXW             = 9;
  localparam int unsigned CoordYW             = 8;
  localparam int unsigned PixelW              = 8;
  localparam int unsigned AddrW               = CoordYW + CoordXW;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_WAIT,
    READ_WAIT,
    GAP
  } initiator_state_t;

  typedef struct packed {
    logic               write;
    logic [CoordYW-1:0] y;
    logic [CoordXW-1:0] x;
    logic [PixelW-1:0]  data;
  } mem_cmd_t;

  function automatic logic [AddrW-1:0] pixel_addr(input mem_cmd_t cmd);
    return {cmd.y, cmd.x};
  endfunction

endpackage

// File: rtl/command_fifo.sv
// Small synchronous FIFO of mem_cmd_t entries.
//   i_clock, i_reset : clock, asynchronous active-high reset (flushes pointers)
//   i_push, i_data   : enqueue an entry (accepted when not full, or when popping while full)
//   i_pop, o_head    : dequeue; o_head is the current head entry
//   o_full, o_empty  : status from read/write pointers carrying an extra wrap bit
module command_fifo
  import g76_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     i_clock,
  input  logic     i_reset,
  input  logic     i_push,
  input  mem_cmd_t i_data,
  input  logic     i_pop,
  output mem_cmd_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  mem_cmd_t    r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_push;
  logic        w_do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge i_clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/memory_request_initiator.sv
// Host-side initiator for the memory manager's CPU port.
//   i_clock, i_reset            : clock, asynchronous active-high reset
//   i_cmd_* / o_cmd_ready       : host pixel command (write flag, x, y, data), valid/ready
//   o_rsp_valid/o_rsp_data      : one-entry read response, held until i_rsp_ready
//   o_drop_count                : out-of-range commands dropped (saturating)
//   o_timeout_error             : sticky, set when a request is abandoned
//   o_memory_*                  : level request, {y, x} address and write data to the manager
//   i_memory_*                  : read data and one-cycle completion pulses from the manager
module memory_request_initiator
  import g76_mem_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SCREEN_WIDTH   = DefaultScreenWidth,
  parameter int unsigned SCREEN_HEIGHT  = DefaultScreenHeight,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_write,
  input  logic [CoordXW-1:0] i_cmd_x,
  input  logic [CoordYW-1:0] i_cmd_y,
  input  logic [PixelW-1:0]  i_cmd_data,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [PixelW-1:0]  o_rsp_data,
  output logic [7:0]         o_drop_count,
  output logic               o_timeout_error,
  output logic [AddrW-1:0]   o_memory_address,
  output logic               o_memory_read_request,
  output logic               o_memory_write_request,
  output logic [PixelW-1:0]  o_memory_write_data,
  input  logic [PixelW-1:0]  i_memory_read_data,
  input  logic               i_memory_read_complete,
  input  logic               i_memory_write_complete
);

  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES);

  initiator_state_t      r_state;
  logic [TimeoutW-1:0]   r_wait_cnt;
  logic                  r_ready_en;
  logic                  r_rd_req;
  logic                  r_wr_req;
  logic [AddrW-1:0]      r_addr;
  logic [PixelW-1:0]     r_wdata;
  logic                  r_rsp_valid;
  logic [PixelW-1:0]     r_rsp_data;
  logic [7:0]            r_drop_cnt;
  logic                  r_timeout_err;

  mem_cmd_t w_cmd_in;
  mem_cmd_t w_head;
  logic     w_full;
  logic     w_empty;
  logic     w_accept;
  logic     w_in_range;
  logic     w_push;
  logic     w_pop;
  logic     w_timeout;
  logic     w_capture;

  // Ready is held low through reset and for the first edge after it.
  assign o_cmd_ready = r_ready_en && !w_full;
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_in_range  = (32'(i_cmd_x) < SCREEN_WIDTH) && (32'(i_cmd_y) < SCREEN_HEIGHT);
  assign w_push      = w_accept && w_in_range;
  assign w_cmd_in    = '{write: i_cmd_write, y: i_cmd_y, x: i_cmd_x, data: i_cmd_data};

  // A read at the head must wait until the previous response has been consumed.
  assign w_pop     = (r_state == IDLE) && !w_empty && (w_head.write || !r_rsp_valid);
  assign w_timeout = (r_wait_cnt == TimeoutW'(TIMEOUT_CYCLES - 1));
  assign w_capture = (r_state == READ_WAIT) && i_memory_read_complete;

  command_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_command_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_wait_cnt    <= '0;
      r_rd_req      <= 1'b0;
      r_wr_req      <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_addr     <= pixel_addr(w_head);
            r_wdata    <= w_head.data;
            r_wait_cnt <= '0;
            if (w_head.write) begin
              r_wr_req <= 1'b1;
              r_state  <= WRITE_WAIT;
            end else begin
              r_rd_req <= 1'b1;
              r_state  <= READ_WAIT;
            end
          end
        end
        WRITE_WAIT: begin
          // Completion wins over a timeout landing on the same edge.
          if (i_memory_write_complete) begin
            r_wr_req <= 1'b0;
            r_state  <= GAP;
          end else if (w_timeout) begin
            r_wr_req      <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= GAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + TimeoutW'(1);
          end
        end
        READ_WAIT: begin
          if (i_memory_read_complete) begin
            r_rd_req <= 1'b0;
            r_state  <= GAP;
          end else if (w_timeout) begin
            r_rd_req      <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= GAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + TimeoutW'(1);
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Response buffer: a capture takes priority over a same-cycle consume.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= i_memory_read_data;
    end else if (r_rsp_valid && i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ready_en <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept && !w_in_range && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign o_rsp_valid            = r_rsp_valid;
  assign o_rsp_data             = r_rsp_data;
  assign o_drop_count           = r_drop_cnt;
  assign o_timeout_error        = r_timeout_err;
  assign o_memory_address       = r_addr;
  assign o_memory_read_request  = r_rd_req;
  assign o_memory_write_request = r_wr_req;
  assign o_memory_write_data    = r_wdata;

endmodule

// File: tb/tb_memory_request_initiator.sv
module tb_memory_request_initiator;

  localparam int unsigned Depth   = 4;
  localparam int unsigned Width   = 320;
  localparam int unsigned Height  = 240;
  localparam int unsigned Timeout = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [8:0]  cmd_x = '0;
  logic [7:0]  cmd_y = '0;
  logic [7:0]  cmd_data = '0;
  logic        rsp_ready = 1'b0;
  logic        mem_wc = 1'b0;
  logic        mem_rc = 1'b0;
  logic [7:0]  mem_rd = '0;

  logic        o_cmd_ready;
  logic        o_rsp_valid;
  logic [7:0]  o_rsp_data;
  logic [7:0]  o_drop_count;
  logic        o_timeout_error;
  logic [16:0] o_memory_address;
  logic        o_memory_read_request;
  logic        o_memory_write_request;
  logic [7:0]  o_memory_write_data;

  always #5 clk = ~clk;

  memory_request_initiator #(
    .FIFO_DEPTH     (Depth),
    .SCREEN_WIDTH   (Width),
    .SCREEN_HEIGHT  (Height),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .i_clock                 (clk),
    .i_reset                 (rst),
    .i_cmd_valid             (cmd_valid),
    .o_cmd_ready             (o_cmd_ready),
    .i_cmd_write             (cmd_write),
    .i_cmd_x                 (cmd_x),
    .i_cmd_y                 (cmd_y),
    .i_cmd_data              (cmd_data),
    .o_rsp_valid             (o_rsp_valid),
    .i_rsp_ready             (rsp_ready),
    .o_rsp_data              (o_rsp_data),
    .o_drop_count            (o_drop_count),
    .o_timeout_error         (o_timeout_error),
    .o_memory_address        (o_memory_address),
    .o_memory_read_request   (o_memory_read_request),
    .o_memory_write_request  (o_memory_write_request),
    .o_memory_write_data     (o_memory_write_data),
    .i_memory_read_data      (mem_rd),
    .i_memory_read_complete  (mem_rc),
    .i_memory_write_complete (mem_wc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory manager behaviour knobs, set by the stimulus.
  bit         cfg_stall = 0;
  bit         cfg_stray = 0;
  bit         cfg_force_stray = 0;
  bit         cfg_rand_data = 0;
  bit         cfg_rand_rsp = 0;
  int         cfg_lat = 2;
  logic [7:0] cfg_rdata = 8'h00;

  // Transaction-level reference: commands expected to reach the memory port, in order.
  typedef struct {
    bit          write;
    logic [16:0] addr;
    logic [7:0]  data;
  } exp_req_t;

  exp_req_t    exp_q[$];
  int          occ, pend_push, since_rst, low_run, hi_cnt, cur_lat;
  bit          prev_req, expect_fall, cur_write;
  logic [16:0] cur_addr;
  logic [7:0]  cur_data;
  logic        exp_rsp_v, exp_to;
  logic [7:0]  exp_rsp_data, exp_drop;

  // Compare outputs, then drive the memory model for this cycle, then advance the model.
  always @(negedge clk) begin
    logic     rw, rr, rq, cap;
    logic [7:0] rd;
    exp_req_t e;
    if (rst) begin
      chk("reset_outputs_zero", {o_cmd_ready, o_rsp_valid, o_timeout_error,
          o_memory_read_request, o_memory_write_request, o_rsp_data, o_drop_count,
          o_memory_write_data, o_memory_address}, 64'd0);
      exp_q.delete();
      occ = 0; pend_push = 0; since_rst = 0; low_run = 2; hi_cnt = 0; cur_lat = 1;
      prev_req = 0; expect_fall = 0; cur_write = 0; cur_addr = '0; cur_data = '0;
      exp_rsp_v = 0; exp_rsp_data = '0; exp_drop = '0; exp_to = 0;
      mem_wc = 0; mem_rc = 0; mem_rd = '0;
    end else begin
      rw = o_memory_write_request;
      rr = o_memory_read_request;
      rq = rw | rr;
      occ += pend_push;
      pend_push = 0;
      chk("one_request_line", rw && rr, 0);
      if (prev_req) chk("request_hold_or_drop", rq, !expect_fall);
      if (rq && !prev_req) begin
        chk("gap_before_request", low_run >= 2, 1);
        occ--;
        chk("issue_has_expected_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("issue_type", rw, e.write);
          cur_write = e.write; cur_addr = e.addr; cur_data = e.data;
        end else begin
          cur_write = rw; cur_addr = o_memory_address; cur_data = o_memory_write_data;
        end
        hi_cnt  = 0;
        cur_lat = (cfg_lat > 0) ? cfg_lat : int'($urandom_range(1, 6));
      end
      if (rq) begin
        chk("request_address", o_memory_address, cur_addr);
        chk("request_type_stable", rw, cur_write);
        if (rw) chk("write_data", o_memory_write_data, cur_data);
      end
      if (rr) chk("no_pending_rsp_during_read", o_rsp_valid, 0);
      chk("rsp_valid", o_rsp_valid, exp_rsp_v);
      chk("rsp_data", o_rsp_data, exp_rsp_data);
      chk("drop_count", o_drop_count, exp_drop);
      chk("timeout_error", o_timeout_error, exp_to);
      chk("cmd_ready", o_cmd_ready, (since_rst >= 1) && (occ < int'(Depth)));

      // Memory manager model.
      mem_wc = 0; mem_rc = 0; cap = 0;
      rd = cfg_rand_data ? 8'($urandom) : cfg_rdata;
      mem_rd = rd;
      expect_fall = 0;
      if (rq) begin
        hi_cnt++;
        if (!cfg_stall && hi_cnt >= cur_lat) begin
          if (rw) mem_wc = 1;
          else begin
            mem_rc = 1;
            cap = 1;
          end
          expect_fall = 1;
        end else if (hi_cnt >= int'(Timeout)) begin
          expect_fall = 1;
          exp_to = 1;
        end
        // Non-matching pulses must be ignored.
        if (rw && (cfg_force_stray || (cfg_stray && $urandom_range(0, 3) == 0))) mem_rc = 1;
        if (rr && cfg_stray && $urandom_range(0, 3) == 0) mem_wc = 1;
      end else if (cfg_stray && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) mem_wc = 1;
        else mem_rc = 1;
      end

      if (exp_rsp_v && rsp_ready) exp_rsp_v = 0;
      if (cap) begin
        exp_rsp_v = 1;
        exp_rsp_data = rd;
      end
      if (cmd_valid && o_cmd_ready) begin
        if (int'(cmd_x) < int'(Width) && int'(cmd_y) < int'(Height)) begin
          exp_q.push_back('{write: cmd_write, addr: {cmd_y, cmd_x}, data: cmd_data});
          pend_push = 1;
        end else if (exp_drop != 8'hFF) begin
          exp_drop = exp_drop + 8'd1;
        end
      end
      low_run  = rq ? 0 : ((low_run < 2) ? low_run + 1 : 2);
      prev_req = rq;
      if (since_rst < 1000) since_rst++;
    end
  end

  // Stimulus helpers: inputs change and literal checks sample 2 time units after posedge.
  task automatic step();
    @(posedge clk);
    #2;
    if (cfg_rand_rsp) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return o_memory_write_request;
      1:       return o_memory_read_request;
      2:       return o_rsp_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic send(input bit w, input int x, input int y, input int d);
    bit ok;
    ok = 0;
    cmd_valid = 1; cmd_write = w; cmd_x = 9'(x); cmd_y = 8'(y); cmd_data = 8'(d);
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = o_cmd_ready;
      step();
    end
    chk("send_accepted", ok, 1);
    cmd_valid = 0;
  endtask

  task automatic wait_sig(input string name, input int which, input int max_cycles);
    bit seen;
    seen = sig(which);
    for (int i = 0; i < max_cycles && !seen; i++) begin
      step();
      seen = sig(which);
    end
    chk(name, seen, 1);
  endtask

  task automatic count_high(input int which, output int n);
    n = 0;
    while (sig(which) && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic count_window(input int which, input int len, output int n);
    n = 0;
    for (int i = 0; i < len; i++) begin
      if (sig(which)) n++;
      step();
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_cmd_ready_low", o_cmd_ready, 0);
    rst = 0;
    step();
    chk("ready_after_reset", o_cmd_ready, 1);

    // 1: single write, completes after 3 request cycles.
    cfg_lat = 3;
    send(1, 5, 3, 8'hA5);
    wait_sig("t1_write_request", 0, 10);
    chk("t1_address", o_memory_address, 17'h00605);
    chk("t1_write_data", o_memory_write_data, 8'hA5);
    count_high(0, n);
    chk("t1_request_cycles", n, 3);
    chk("t1_gap_low", {o_memory_write_request, o_memory_read_request}, 0);
    drain(3);

    // 2: read at the far corner, response held until consumed.
    cfg_lat = 2; cfg_rdata = 8'h3C; rsp_ready = 0;
    send(0, 319, 239, 0);
    wait_sig("t2_read_request", 1, 10);
    chk("t2_address", o_memory_address, 17'h1DF3F);
    wait_sig("t2_rsp_valid", 2, 20);
    chk("t2_rsp_data", o_rsp_data, 8'h3C);
    drain(5);
    chk("t2_rsp_held", {o_rsp_valid, o_rsp_data}, {1'b1, 8'h3C});
    rsp_ready = 1;
    step();
    chk("t2_rsp_consumed", o_rsp_valid, 0);

    // 3: five writes against a stalled manager fill the FIFO.
    cfg_stall = 1;
    for (int i = 0; i < 5; i++) send(1, 20 + i, 30 + i, 8'h10 + i);
    chk("t3_ready_full", o_cmd_ready, 0);
    cfg_stall = 0;
    drain(60);
    chk("t3_ready_after_drain", o_cmd_ready, 1);

    // 4: out-of-range commands are handshaken and dropped.
    send(1, 320, 0, 1);
    send(1, 0, 240, 2);
    chk("t4_drop_count", o_drop_count, 2);
    count_window(0, 4, n);
    chk("t4_no_issue", n, 0);
    send(1, 7, 9, 8'h11);
    wait_sig("t4_write_request", 0, 10);
    chk("t4_address", o_memory_address, 17'h01207);
    drain(10);

    // 5: pending response blocks a read at the head and the write behind it.
    rsp_ready = 0; cfg_rdata = 8'h77;
    send(0, 1, 1, 0);
    wait_sig("t5_first_rsp", 2, 20);
    send(0, 3, 3, 0);
    send(1, 2, 2, 8'h22);
    count_window(1, 10, n);
    chk("t5_read_blocked", n, 0);
    count_window(0, 1, n);
    chk("t5_write_blocked", n, 0);
    rsp_ready = 1;
    wait_sig("t5_read_issued", 1, 10);
    chk("t5_read_address", o_memory_address, 17'h00603);
    wait_sig("t5_write_issued", 0, 20);
    chk("t5_write_address", o_memory_address, 17'h00402);
    chk("t5_write_data", o_memory_write_data, 8'h22);
    drain(10);

    // 6a: manager never completes.
    cfg_stall = 1;
    send(1, 10, 10, 8'h55);
    wait_sig("t6_write_request", 0, 10);
    count_high(0, n);
    chk("t6_timeout_cycles", n, Timeout);
    step();
    chk("t6_timeout_error", o_timeout_error, 1);
    cfg_stall = 0;
    drain(3);

    // 6b: stray read-complete pulses during WRITE_WAIT.
    cfg_force_stray = 1; cfg_lat = 4;
    send(1, 11, 11, 8'h66);
    wait_sig("t6b_write_request", 0, 10);
    count_high(0, n);
    chk("t6b_request_cycles", n, 4);
    chk("t6b_no_response", o_rsp_valid, 0);
    cfg_force_stray = 0;
    drain(3);

    // 6c: reset in the middle of WRITE_WAIT with entries queued.
    cfg_stall = 1;
    send(1, 12, 12, 1);
    send(1, 13, 13, 2);
    send(1, 14, 14, 3);
    wait_sig("t6c_write_request", 0, 10);
    rst = 1;
    #1;
    chk("t6c_request_dropped", o_memory_write_request, 0);
    chk("t6c_timeout_cleared", o_timeout_error, 0);
    step();
    step();
    rst = 0;
    cfg_stall = 0;
    count_window(0, 10, n);
    chk("t6c_fifo_flushed", n, 0);
    chk("t6c_ready", o_cmd_ready, 1);

    // Randomized traffic checked by the reference model.
    cfg_lat = 0; cfg_stray = 1; cfg_rand_data = 1; cfg_rand_rsp = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) step();
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 335)),
           int'($urandom_range(0, 250)), int'($urandom_range(0, 255)));
    end
    cfg_rand_rsp = 0;
    rsp_ready = 1;
    drain(100);
    chk("random_all_issued", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
